// File: rtl/ram_encode_pkg.sv
// Shared constants for the address<->code table pair: widths, table contents and
// the encoder FSM states. Both directions read CODE_TABLE so they cannot drift apart.
package ram_encode_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    // Strictly increasing; the encoder's floor search depends on that ordering.
    localparam logic [DEF_DATA_W-1:0] CODE_TABLE [0:(1<<DEF_ADDR_W)-1] = '{
        8'h03, 8'h08, 8'h0D, 8'h14, 8'h19, 8'h1E, 8'h25, 8'h2A,
        8'h2C, 8'h31, 8'h36, 8'h3D, 8'h46, 8'h50, 8'h59, 8'h6C
    };

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/ram_table_rom.sv
// Combinational index -> code lookup over the shared table constants.
module ram_table_rom
    import ram_encode_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [ADDR_W-1:0] idx,
    output logic [DATA_W-1:0] code
);

    assign code = CODE_TABLE[idx];

endmodule

// File: rtl/ram_encode.sv
// Code -> address encoder: walks the table one entry per clock and returns the exact
// or floor index of the latched key, flagging keys below the first entry.
module ram_encode
    import ram_encode_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic              below
);

    // Handshake: start is taken only in IDLE with en=1 (including the done cycle);
    // busy covers the scan, done pulses once, and addr/hit/below hold until the next done.
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] key_q, key_d;
    logic              busy_d, done_d, hit_d, below_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] code;
    logic              finish;

    ram_table_rom #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_rom (
        .idx (idx_q),
        .code(code)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        key_d   = key_q;
        busy_d  = busy;
        done_d  = 1'b0;
        addr_d  = addr;
        hit_d   = hit;
        below_d = below;
        finish  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && start) begin
                    key_d   = data_in;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (en) begin
                    if (code == key_q) begin
                        finish  = 1'b1;
                        addr_d  = idx_q;
                        hit_d   = 1'b1;
                        below_d = 1'b0;
                    end else if (code > key_q) begin
                        finish  = 1'b1;
                        hit_d   = 1'b0;
                        // First entry already above the key: nothing to floor to.
                        if (idx_q == '0) begin
                            addr_d  = '0;
                            below_d = 1'b1;
                        end else begin
                            addr_d  = idx_q - ADDR_W'(1);
                            below_d = 1'b0;
                        end
                    end else if (idx_q == LAST_IDX) begin
                        finish  = 1'b1;
                        addr_d  = LAST_IDX;
                        hit_d   = 1'b0;
                        below_d = 1'b0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                    if (finish) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            key_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            addr    <= '0;
            hit     <= 1'b0;
            below   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            key_q   <= key_d;
            busy    <= busy_d;
            done    <= done_d;
            addr    <= addr_d;
            hit     <= hit_d;
            below   <= below_d;
        end
    end

endmodule

// File: doc/ram_encode.md
Name: ram_encode

Overview:
- Inverse of the 16-entry address-to-code decode table: takes an 8-bit code and returns the 4-bit address that produces it.
- Table entries are strictly increasing. The block scans them sequentially, one entry per clock.
- Reports an exact hit or the floor index (largest entry <= key). Flags keys below the smallest entry.
- Sits beside the decode table in the datapath so codes captured downstream can be mapped back to table indices.

Parameters:
- ADDR_W, 4, index width; table depth = 2**ADDR_W = 16.
- DATA_W, 8, code width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  enable; when low, the FSM holds its state and index, and start is ignored.
- start  input  1  request; sampled only in IDLE with en=1.
- data_in  input  DATA_W  key; latched on accepted start.
- busy  output  1  high from the edge after start acceptance until the terminating edge.
- done  output  1  one-cycle pulse; addr, hit and below are valid from this cycle.
- addr  output  ADDR_W  matched index or floor index; held until the next done.
- hit  output  1  exact match.
- below  output  1  key < table[0].

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Table contents, index 0..15, in hex: 03 08 0D 14 19 1E 25 2A 2C 31 36 3D 46 50 59 6C.
- Reset: state=IDLE, idx=0, key=0, busy=0, done=0, addr=0, hit=0, below=0.
  - Reset mid-scan aborts the search. No done pulse is produced.
- States: IDLE, SCAN.
- IDLE:
  - done is cleared every cycle, so it is high for exactly one cycle.
  - On an edge with en=1 and start=1: latch key=data_in, idx=0, busy=1, go to SCAN.
- SCAN: each edge with en=1 compares table[idx] with key. Terminate on the first true condition, in this order:
  - table[idx]==key: addr=idx, hit=1, below=0.
  - table[idx]>key and idx==0: addr=0, hit=0, below=1.
  - table[idx]>key: addr=idx-1, hit=0, below=0.
  - idx==15 (key > 0x6C): addr=15, hit=0, below=0.
  - Otherwise: idx=idx+1, stay in SCAN. idx never wraps.
- On the terminating edge: done=1, busy=0, next state IDLE.
- en=0 in SCAN freezes idx, state and outputs. The scan resumes when en returns to 1.
- Latency: if the scan terminates at index k, done rises k+2 edges after the start-accept edge (accept edge, then k+1 compare edges).
  - Minimum: 2 edges (k=0).
  - Maximum: 17 edges (k=15).
- start while busy=1 is ignored; the key is not re-latched.
- start in the cycle done=1 (state is IDLE) is accepted.
  - addr, hit and below keep their previous values until the new done.
- data_in changes after acceptance have no effect.
- Comparisons are unsigned, DATA_W bits. No arithmetic beyond the idx increment and idx-1. idx-1 is evaluated only when idx>0.

Decomposition:
- Shared package/include holds:
  - ADDR_W and DATA_W defaults.
  - The 16 table constants, used by both the decode table and this block, so the two directions cannot diverge.
  - State encodings IDLE=1'b0, SCAN=1'b1.
- One sub-module, ram_table_rom: purely combinational index -> code lookup built from the package constants. ram_encode instantiates it, driving idx.
- The FSM, key register and output registers live in ram_encode.

Test Plan:
- Reset, then start with data_in=0x03 -> done at edge 2 after accept; addr=0, hit=1, below=0; busy high for exactly 1 cycle.
- data_in=0x6C -> done 17 edges after accept; addr=15, hit=1.
- Inexact keys:
  - data_in=0x2B -> addr=7, hit=0, below=0, done 10 edges after accept.
  - data_in=0xFF -> addr=15, hit=0, below=0, 17 edges.
  - data_in=0x02 -> addr=0, below=1, hit=0, 2 edges.
- data_in=0x46 with en held low for 3 cycles mid-scan -> done delayed by exactly 3 cycles; addr=12, hit=1. Re-pulse start while busy -> ignored, result unchanged.
- Start key 0x50, assert rst at scan edge 5 -> the next cycle shows busy=0, done=0, addr=0, hit=0, below=0, and no done pulse follows. Restart with 0x19 -> addr=4, hit=1.
- Back-to-back: start held high continuously with keys 0x08 then 0x31 -> second request accepted in the done cycle; results addr=1 then addr=9, both hit=1; exactly one done pulse per request.
